mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Responder side of the core's memory-mapped I/O path: consumes the execute-stage store/load requests (`mem_wen`-qualified address/data) that target the I/O region.
- Returns registered read data to the writeback mux.
- Owns the UART byte buffers (ready/valid to the UART TX/RX) and the cycle and instruction performance counters.
- Sits beside the data memory; selected when addr[31:28] matches BASE_ADDR[31:28].

Parameters:
BASE_ADDR, 32'h8000_0000, base of the I/O region; register offsets below are relative to it
CNT_WIDTH, 32, width of the cycle and instruction counters (read data is zero-extended/truncated to 32)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
addr  in  32  byte address from execute stage
wdata  in  32  store data (already aligned, byte in [7:0])
wen  in  1  store strobe for this cycle
ren  in  1  load strobe for this cycle
inst_retired  in  1  one instruction retired this cycle
rdata  out  32  registered load data, valid 1 cycle after ren
uart_tx_data  out  8  byte to UART transmitter
uart_tx_valid  out  1  TX byte valid
uart_tx_ready  in  1  UART transmitter accepts byte
uart_rx_data  in  8  byte from UART receiver
uart_rx_valid  in  1  RX byte valid
uart_rx_ready  out  1  responder can accept RX byte

Behaviour:
- Reset values:
  - rdata = 0, uart_tx_valid = 0, uart_tx_data = 0.
  - RX buffer empty, so uart_rx_ready = 1.
  - Both counters = 0.
- Decode:
  - Request is I/O iff addr[31:28] == BASE_ADDR[31:28].
  - Offset = addr[7:0].
  - wen/ren for non-I/O addresses are ignored.
- Register map (offset: access, meaning):
  - 0x00: R. Status: bit0 = TX space (!uart_tx_valid), bit1 = RX data available (rx_full), others 0.
  - 0x04: R. RX byte zero-extended; reading clears rx_full.
  - 0x08: W. TX byte = wdata[7:0].
  - 0x10: R. Cycle counter.
  - 0x14: R. Instruction counter.
  - 0x18: W. Any write clears both counters.
  - Any other offset reads 0; writes are ignored.
- Read latency:
  - rdata is registered; the value is sampled at the edge where ren = 1 and presented the following cycle.
  - rdata holds its value until the next ren.
  - A status read reflects state before any same-cycle update.
- TX FSM (TX_IDLE, TX_PEND):
  - TX_IDLE + write to 0x08: latch byte, go TX_PEND, uart_tx_valid = 1 from the next cycle.
  - TX_PEND + uart_tx_ready: handshake completes; go TX_IDLE, uart_tx_valid = 0 next cycle.
  - A write to 0x08 while in TX_PEND is dropped; the byte is not overwritten. Software must poll status bit0.
  - uart_tx_data stays stable while valid.
- RX buffer:
  - uart_rx_ready = !rx_full.
  - On uart_rx_valid & uart_rx_ready: capture the byte and set rx_full.
  - Read of 0x04 with rx_full = 1: returns the byte and clears rx_full next cycle.
  - Read of 0x04 with rx_full = 0: returns the stale byte; no state change.
  - Capture and clear cannot coincide because ready is low while full.
- Counters:
  - Cycle counter += 1 every cycle.
  - Instruction counter += 1 when inst_retired.
  - Both wrap modulo 2^CNT_WIDTH.
  - A write to 0x18 forces both to 0 next cycle; the clear overrides a same-cycle increment.
- Simultaneous wen and ren in one cycle: both honoured; the write side effect and the registered read are independent.
- rst asserted mid-operation (e.g. TX_PEND):
  - Returns all state to reset values at the next edge.
  - A pending TX byte is discarded with no handshake; a buffered RX byte is lost.

Test Plan:
- Reset, then read 0x00 -> rdata = 32'h1 one cycle after ren; uart_rx_ready = 1, uart_tx_valid = 0.
- TX path:
  - Stimulus: write 0x41 to 0x8000_0008 with uart_tx_ready held 0 for 5 cycles, then write 0x42 to 0x08, then raise uart_tx_ready for one cycle.
  - Response: uart_tx_valid = 1 with uart_tx_data = 8'h41 throughout; the 0x42 write is dropped; status bit0 = 0 while pending; after the handshake, valid = 0 and status = 32'h1.
- RX path:
  - Stimulus: uart_rx_valid with byte 0x5A, then read 0x00, then read 0x04.
  - Response: uart_rx_ready drops to 0 after capture; status = 32'h3; 0x04 read returns 32'h5A; uart_rx_ready = 1 the cycle after the read.
- Counters:
  - Stimulus: run 100 cycles after reset with inst_retired asserted every 2nd cycle, then read 0x10 and 0x14.
  - Response: 0x10 read returns 100 ± the read-sample cycle offset exactly as computed by the model; 0x14 read returns 50.
  - Follow-up: write 0x18 in a cycle where inst_retired = 1, then read 0x14 immediately -> both counters are 0 the cycle after the write; the 0x14 read returns 0.
- Wrap: preload the cycle counter via force to 32'hFFFF_FFFF -> next value is 0.
- Edge cases:
  - Read of 0x8000_0020 or 0x0000_0010 -> rdata = 0 and no side effects.
  - rst asserted while in TX_PEND -> uart_tx_valid = 0 the next cycle.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O responder for the core's load/store path.
// It decodes the I/O region and returns registered load data. It also owns
// the UART TX/RX byte buffers and the cycle and instruction counters.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // Register offsets inside the I/O region (low address byte only)
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  typedef enum logic {
    TX_IDLE,
    TX_PEND
  } tx_state_t;

  tx_state_t            tx_state;
  tx_state_t            tx_state_next;
  logic                 tx_load;
  logic [7:0]           tx_byte;

  logic                 rx_full;
  logic [7:0]           rx_byte;
  logic                 rx_accept;
  logic                 rx_clear;

  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instr_cnt;
  logic [31:0]          cycle_rd;
  logic [31:0]          instr_rd;

  logic                 is_io;
  logic [7:0]           offset;
  logic                 io_wr;
  logic                 io_rd;
  logic                 wr_tx;
  logic                 wr_clear;
  logic                 rd_rx;
  logic [31:0]          status;
  logic [31:0]          read_value;

  // Address bits between the region nibble and the offset byte, and the upper
  // store-data bits, carry no meaning for this block.
  logic                 unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  // Region decode: only the top nibble selects the I/O space
  assign is_io    = (addr[31:28] == BASE_ADDR[31:28]);
  assign offset   = addr[7:0];
  assign io_wr    = wen & is_io;
  assign io_rd    = ren & is_io;
  assign wr_tx    = io_wr & (offset == OFF_TX);
  assign wr_clear = io_wr & (offset == OFF_CLEAR);
  assign rd_rx    = io_rd & (offset == OFF_RX);

  // Status is built from the current (pre-edge) buffer state
  assign status = {30'b0, rx_full, ~uart_tx_valid};

  // Counters are presented as 32-bit read data regardless of their width
  generate
    if (CNT_WIDTH >= 32) begin : g_cnt_trunc
      assign cycle_rd = cycle_cnt[31:0];
      assign instr_rd = instr_cnt[31:0];
    end else begin : g_cnt_ext
      assign cycle_rd = {{(32 - CNT_WIDTH){1'b0}}, cycle_cnt};
      assign instr_rd = {{(32 - CNT_WIDTH){1'b0}}, instr_cnt};
    end
  endgenerate

  // Read-data mux: selects the register addressed this cycle, zero otherwise
  always_comb begin
    read_value = 32'h0;
    if (is_io) begin
      case (offset)
        OFF_STATUS: read_value = status;
        OFF_RX:     read_value = {24'h0, rx_byte};
        OFF_CYCLE:  read_value = cycle_rd;
        OFF_INSTR:  read_value = instr_rd;
        default:    read_value = 32'h0;
      endcase
    end
  end

  // Load data register: captures on every load strobe and holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0;
    end else if (ren) begin
      rdata <= read_value;
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_next;
    end
  end

  // TX next state: accept a byte only when idle, release it on handshake
  always_comb begin
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (wr_tx) begin
          tx_state_next = TX_PEND;
          tx_load       = 1'b1;
        end
      end
      TX_PEND: begin
        if (uart_tx_ready) begin
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // TX byte register: only loaded when idle, so it is stable while valid
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte <= 8'h00;
    end else if (tx_load) begin
      tx_byte <= wdata[7:0];
    end
  end

  assign uart_tx_valid = (tx_state == TX_PEND);
  assign uart_tx_data  = tx_byte;

  // RX buffer control: ready is low while full, so capture and clear never meet
  assign uart_rx_ready = ~rx_full;
  assign rx_accept     = uart_rx_valid & ~rx_full;
  assign rx_clear      = rd_rx & rx_full;

  // RX single-byte buffer with its full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (rx_accept) begin
      rx_full <= 1'b1;
      rx_byte <= uart_rx_data;
    end else if (rx_clear) begin
      rx_full <= 1'b0;
    end
  end

  // Cycle counter: free-running, clear write wins over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (wr_clear) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  // Instruction counter: counts retirements, clear write wins over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (wr_clear) begin
      instr_cnt <= '0;
    end else if (inst_retired) begin
      instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: a vector table for the register map
// and UART paths, then hand-written sequences for counters, wrap and reset.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic        inst_retired;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  mmio_responder #(
    .BASE_ADDR(BASE),
    .CNT_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wdata        (wdata),
    .wen          (wen),
    .ren          (ren),
    .inst_retired (inst_retired),
    .rdata        (rdata),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] exp_rdata;
    logic        exp_tx_valid;
    logic [7:0]  exp_tx_data;
    logic        exp_rx_ready;
  } vec_t;

  vec_t        vecs[$];
  string       vnames[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;
  int          n_checks;
  int          n_fail;

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addVec(input string nm, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic w, input logic rd,
                        input logic txr, input logic [7:0] rxd, input logic rxv,
                        input logic [31:0] er, input logic etv,
                        input logic [7:0] etd, input logic err);
    vec_t v;
    v.rst = r; v.addr = a; v.wdata = wd; v.wen = w; v.ren = rd;
    v.tx_ready = txr; v.rx_data = rxd; v.rx_valid = rxv;
    v.exp_rdata = er; v.exp_tx_valid = etv; v.exp_tx_data = etd;
    v.exp_rx_ready = err;
    vecs.push_back(v);
    vnames.push_back(nm);
  endtask

  // Drives one cycle of inputs, queues the expected load data and advances the
  // counter model across the active edge; returns on the following negedge.
  task automatic applyStimulus(input logic r, input logic [31:0] a,
                               input logic [31:0] wd, input logic w,
                               input logic rd, input logic in,
                               input logic txr, input logic [7:0] rxd,
                               input logic rxv, input logic [31:0] er);
    rst = r; addr = a; wdata = wd; wen = w; ren = rd; inst_retired = in;
    uart_tx_ready = txr; uart_rx_data = rxd; uart_rx_valid = rxv;
    if (rd && !r) exp_q.push_back(er);
    @(posedge clk);
    if (r) begin
      m_cyc = 32'h0;
      m_ins = 32'h0;
      exp_q.delete();
      last_exp = 32'h0;
    end else if (w && a[31:28] == BASE[31:28] && a[7:0] == 8'h18) begin
      m_cyc = 32'h0;
      m_ins = 32'h0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (in) m_ins = m_ins + 32'd1;
    end
    @(negedge clk);
  endtask

  // Pops the scoreboard if a load completed, otherwise rdata must hold
  task automatic checkOutput(input string nm);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      compare({nm, ":rdata"}, rdata, last_exp);
    end else begin
      compare({nm, ":rdata_hold"}, rdata, last_exp);
    end
  endtask

  task automatic idle(input logic in);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, in, 1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic readReg(input logic [31:0] a, input logic [31:0] er);
    applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, er);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_cyc = 32'h0; m_ins = 32'h0; last_exp = 32'h0;
    rst = 1'b1; addr = 32'h0; wdata = 32'h0; wen = 1'b0; ren = 1'b0;
    inst_retired = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = 8'h00;
    uart_rx_valid = 1'b0;

    //      name             rst addr          wdata     wen ren txr rxd    rxv exp_rdata  txv txd    rxr
    addVec("reset",          1, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     0, 8'h00, 1);
    addVec("stat_idle",      0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h1,     0, 8'h00, 1);
    addVec("tx_wr41",        0, BASE + 32'h8, 32'h41,   1, 0, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_wait1",       0, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_stat_pend",   0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_wait2",       0, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_wait3",       0, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_wr42_drop",   0, BASE + 32'h8, 32'h42,   1, 0, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_stat_pend2",  0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h0,     1, 8'h41, 1);
    addVec("tx_handshake",   0, 32'h0,        32'h0,    0, 0, 1, 8'h00, 0, 32'h0,     0, 8'h41, 1);
    addVec("tx_stat_done",   0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h1,     0, 8'h41, 1);
    addVec("tx_ready_idle",  0, 32'h0,        32'h0,    0, 0, 1, 8'h00, 0, 32'h0,     0, 8'h41, 1);
    addVec("wr_rd_same",     0, BASE + 32'h8, 32'h33,   1, 1, 0, 8'h00, 0, 32'h0,     1, 8'h33, 1);
    addVec("stat_pre_hs",    0, BASE,         32'h0,    0, 1, 1, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("rx_capture",     0, 32'h0,        32'h0,    0, 0, 0, 8'h5A, 1, 32'h0,     0, 8'h33, 0);
    addVec("rx_stat_full",   0, BASE,         32'h0,    0, 1, 0, 8'h77, 1, 32'h3,     0, 8'h33, 0);
    addVec("rx_read",        0, BASE + 32'h4, 32'h0,    0, 1, 0, 8'h00, 0, 32'h5A,    0, 8'h33, 1);
    addVec("rx_read_stale",  0, BASE + 32'h4, 32'h0,    0, 1, 0, 8'h00, 0, 32'h5A,    0, 8'h33, 1);
    addVec("rx_stat_empty",  0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h1,     0, 8'h33, 1);
    addVec("rd_non_io",      0, 32'h0000_0010,32'h0,    0, 1, 0, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("stat_again",     0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h1,     0, 8'h33, 1);
    addVec("rdata_hold",     0, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("rd_off20",       0, BASE + 32'h20,32'h0,    0, 1, 0, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("wr_non_io",      0, 32'h0000_0008,32'h99,   1, 0, 0, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("wr_bad_off",     0, BASE + 32'hC, 32'h99,   1, 0, 0, 8'h00, 0, 32'h0,     0, 8'h33, 1);
    addVec("tx_wr55",        0, BASE + 32'h8, 32'h55,   1, 0, 0, 8'h00, 0, 32'h0,     1, 8'h55, 1);
    addVec("rx_cap66",       0, 32'h0,        32'h0,    0, 0, 0, 8'h66, 1, 32'h0,     1, 8'h55, 0);
    addVec("rst_mid",        1, 32'h0,        32'h0,    0, 0, 0, 8'h00, 0, 32'h0,     0, 8'h00, 1);
    addVec("stat_post_rst",  0, BASE,         32'h0,    0, 1, 0, 8'h00, 0, 32'h1,     0, 8'h00, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].addr, vecs[i].wdata, vecs[i].wen,
                    vecs[i].ren, 1'b0, vecs[i].tx_ready, vecs[i].rx_data,
                    vecs[i].rx_valid, vecs[i].exp_rdata);
      checkOutput(vnames[i]);
      compare({vnames[i], ":tx_valid"}, {31'h0, uart_tx_valid}, {31'h0, vecs[i].exp_tx_valid});
      compare({vnames[i], ":tx_data"},  {24'h0, uart_tx_data},  {24'h0, vecs[i].exp_tx_data});
      compare({vnames[i], ":rx_ready"}, {31'h0, uart_rx_ready}, {31'h0, vecs[i].exp_rx_ready});
    end

    // Counters: 100 cycles after reset with a retirement every second cycle
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("cnt_reset");
    for (int i = 0; i < 100; i++) begin
      idle(i[0]);
      checkOutput("cnt_run");
    end
    readReg(BASE + 32'h10, m_cyc);
    checkOutput("cycle_read");
    readReg(BASE + 32'h14, m_ins);
    checkOutput("instr_read");
    compare("instr_count_50", rdata, 32'd50);

    // Clear write coinciding with a retirement, then read back both counters
    applyStimulus(1'b0, BASE + 32'h18, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("cnt_clear");
    readReg(BASE + 32'h14, m_ins);
    checkOutput("instr_after_clear");
    compare("instr_zero", rdata, 32'h0);
    readReg(BASE + 32'h10, m_cyc);
    checkOutput("cycle_after_clear");

    // Wrap: preload the cycle counter to all ones, it must roll over to 0
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    idle(1'b0);
    checkOutput("wrap_forced");
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFF;
    readReg(BASE + 32'h10, m_cyc);
    checkOutput("wrap_max");
    readReg(BASE + 32'h10, m_cyc);
    checkOutput("wrap_zero");

    // Reset while a TX byte is pending drops valid with no handshake
    applyStimulus(1'b0, BASE + 32'h8, 32'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    compare("pend_valid", {31'h0, uart_tx_valid}, 32'h1);
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    compare("rst_pend_valid", {31'h0, uart_tx_valid}, 32'h0);
    checkOutput("rst_pend");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
